// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared state encoding, default mailbox constants, word-index helper
// Revision: 1.0
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    localparam logic [31:0] DEF_PASS_ADDR      = 32'd100;
    localparam logic [31:0] DEF_EXPECT_VAL     = 32'd25;
    localparam int          DEF_TIMEOUT_CYCLES = 1000;

    // Byte address to word index; callers truncate to their RAM address width.
    function automatic logic [29:0] word_index(input logic [31:0] adr);
        return adr[31:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_mailbox_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_mailbox_if
// Brief   : Core data-port bus between the processor and the data memory
// Revision: 1.0
// ============================================================================
interface dmem_mailbox_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output DataAdr,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  DataAdr,
        input  WriteData,
        output ReadData
    );
endinterface
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module  : dmem_ram
// Brief   : DEPTH x 32 RAM, synchronous write, asynchronous read, addr-valid gate
// Revision: 1.0
// ============================================================================
module dmem_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic          addr_valid,
    input  wire logic [AW-1:0] addr,
    input  wire logic [31:0]   wdata,
    output logic      [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    // Contents are intentionally not reset so program images survive reset.
    always_ff @(posedge clk) begin
        if (we && addr_valid) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (addr_valid) begin
            rdata = mem_q[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_mailbox.sv
`default_nettype none
// ============================================================================
// Module  : dmem_mailbox
// Brief   : Data memory with test mailbox, watchdog and run status.
//           Optional DMEM_MISALIGN_TRAP_EN turns misaligned RUN stores into FAIL.
// Revision: 1.0
// ============================================================================
module dmem_mailbox
    import dmem_pkg::*;
#(
    parameter int          DEPTH          = 64,
    parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
    parameter logic [31:0] EXPECT_VAL     = DEF_EXPECT_VAL,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          CNT_W          = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    dmem_mailbox_if.slave         bus,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [31:0]           result,
    output logic [CNT_W-1:0]      store_cnt,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic                  oor_err
);

    localparam int                AW        = $clog2(DEPTH);
    localparam logic [31:0]       RANGE_END = 32'(DEPTH * 4);
    localparam logic [CNT_W-1:0]  LAST_CYC  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q,     state_d;
    logic              pass_q,      pass_d;
    logic              fail_q,      fail_d;
    logic              timeout_q,   timeout_d;
    logic              oor_err_q,   oor_err_d;
    logic [31:0]       result_q,    result_d;
    logic [CNT_W-1:0]  store_cnt_q, store_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

    logic              in_range;
    logic              misalign;
    logic              ram_we;
    logic [AW-1:0]     word_idx;

    assign in_range = (bus.DataAdr < RANGE_END);
    assign word_idx = AW'(word_index(bus.DataAdr));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = bus.MemWrite && (bus.DataAdr[1:0] != 2'b00) && (state_q == ST_RUN);
`else
    assign misalign = 1'b0;
`endif

    assign ram_we = bus.MemWrite && !misalign;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk        (clk),
        .we         (ram_we),
        .addr_valid (in_range),
        .addr       (word_idx),
        .wdata      (bus.WriteData),
        .rdata      (bus.ReadData)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        store_cnt_d = store_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        oor_err_d   = oor_err_q | (bus.MemWrite & ~in_range);

        if (state_q == ST_RUN) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
            if (bus.MemWrite && (store_cnt_q != '1)) begin
                store_cnt_d = store_cnt_q + 1'b1;
            end

            // Mailbox store outranks watchdog expiry in the same cycle.
            if (misalign) begin
                state_d  = ST_FAIL;
                result_d = bus.DataAdr;
            end else if (bus.MemWrite && (bus.DataAdr == PASS_ADDR)) begin
                result_d = bus.WriteData;
                state_d  = (bus.WriteData == EXPECT_VAL) ? ST_PASS : ST_FAIL;
            end else if (cycle_cnt_q == LAST_CYC) begin
                state_d = ST_TIMEOUT;
            end
        end

        pass_d    = (state_d == ST_PASS);
        fail_d    = (state_d == ST_FAIL);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            oor_err_q   <= 1'b0;
            result_q    <= 32'd0;
            store_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            oor_err_q   <= oor_err_d;
            result_q    <= result_d;
            store_cnt_q <= store_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign done      = pass_q | fail_q | timeout_q;
    assign oor_err   = oor_err_q;
    assign result    = result_q;
    assign store_cnt = store_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mailbox.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_mailbox
// Brief   : Directed self-checking bench for dmem_mailbox (watchdog set to 20)
// Revision: 1.0
// ============================================================================
module tb_dmem_mailbox;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             done, pass, fail, timeout, oor_err;
    logic [31:0]      result;
    logic [CNT_W-1:0] store_cnt, cycle_cnt;

    int vectors     = 0;
    int miscompares = 0;

    dmem_mailbox_if bus ();

    dmem_mailbox #(
        .DEPTH          (64),
        .PASS_ADDR      (32'd100),
        .EXPECT_VAL     (32'd25),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .result    (result),
        .store_cnt (store_cnt),
        .cycle_cnt (cycle_cnt),
        .oor_err   (oor_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] dat);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = adr;
        bus.WriteData = dat;
        tick();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        bus.DataAdr = adr;
        #1;
        chk(tag, bus.ReadData, exp);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.MemWrite = 1'b0;
        tick();
        reset        = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'd0;
        bus.WriteData = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_done",      32'(done),      32'd0);
        chk("rst_pass",      32'(pass),      32'd0);
        chk("rst_fail",      32'(fail),      32'd0);
        chk("rst_timeout",   32'(timeout),   32'd0);
        chk("rst_oor",       32'(oor_err),   32'd0);
        chk("rst_result",    result,         32'd0);
        chk("rst_store_cnt", 32'(store_cnt), 32'd0);
        chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);

        // Mailbox pass
        store(32'd96, 32'd7);
        chk("t1_pass_early", 32'(pass), 32'd0);
        store(32'd100, 32'd25);
        chk("t1_pass",      32'(pass),      32'd1);
        chk("t1_done",      32'(done),      32'd1);
        chk("t1_fail",      32'(fail),      32'd0);
        chk("t1_result",    result,         32'd25);
        chk("t1_store_cnt", 32'(store_cnt), 32'd2);
        chk("t1_cycle_cnt", 32'(cycle_cnt), 32'd2);
        read_chk("t1_rd96", 32'd96, 32'd7);

        // Mailbox fail, then frozen against a later good store
        do_reset();
        chk("t2_rst_pass", 32'(pass), 32'd0);
        store(32'd100, 32'd24);
        chk("t2_fail",   32'(fail), 32'd1);
        chk("t2_result", result,    32'd24);
        store(32'd100, 32'd25);
        chk("t2_fail_hold",   32'(fail), 32'd1);
        chk("t2_pass_hold",   32'(pass), 32'd0);
        chk("t2_result_hold", result,    32'd24);
        chk("t2_cnt_frozen",  32'(store_cnt), 32'd1);
        read_chk("t2_rd100", 32'd100, 32'd25);

        // Plain RAM read-back and isolation between words
        do_reset();
        store(32'd12, 32'h1234_5678);
        store(32'd8,  32'hDEAD_BEEF);
        read_chk("t3_rd8",  32'd8,  32'hDEAD_BEEF);
        read_chk("t3_rd12", 32'd12, 32'h1234_5678);
        read_chk("t3_rd9_lowbits", 32'd9, 32'hDEAD_BEEF);
        chk("t3_done", 32'(done), 32'd0);

        // Out-of-range store and read
        do_reset();
        store(32'd0, 32'hA5A5_A5A5);
        read_chk("t5_oor_rd_noflag_rd", 32'h400, 32'd0);
        tick();
        chk("t5_oor_read_noflag", 32'(oor_err), 32'd0);
        store(32'h400, 32'h0000_0055);
        chk("t5_oor_set", 32'(oor_err), 32'd1);
        chk("t5_done",    32'(done),    32'd0);
        read_chk("t5_rd400", 32'h400, 32'd0);
        read_chk("t5_rd0",   32'd0,   32'hA5A5_A5A5);
        tick();
        chk("t5_oor_sticky", 32'(oor_err), 32'd1);
        do_reset();
        chk("t5_oor_clr",  32'(oor_err), 32'd0);
        chk("t5_rst_done", 32'(done),    32'd0);

        // Watchdog: 20 RUN cycles, then terminal
        do_reset();
        repeat (19) tick();
        chk("t4_cnt19",      32'(cycle_cnt), 32'd19);
        chk("t4_no_timeout", 32'(timeout),   32'd0);
        tick();
        chk("t4_timeout",    32'(timeout),   32'd1);
        chk("t4_done",       32'(done),      32'd1);
        chk("t4_cnt20",      32'(cycle_cnt), 32'd20);
        tick();
        chk("t4_cnt_frozen", 32'(cycle_cnt), 32'd20);

        // Mailbox store on the expiry cycle wins
        do_reset();
        repeat (19) tick();
        store(32'd100, 32'd25);
        chk("t4b_pass",    32'(pass),      32'd1);
        chk("t4b_timeout", 32'(timeout),   32'd0);
        chk("t4b_cnt",     32'(cycle_cnt), 32'd20);

        // Misaligned store next to the mailbox word (RAM[25] holds 25 here)
        do_reset();
        store(32'd101, 32'h0000_0077);
        chk("t6_store_cnt", 32'(store_cnt), 32'd1);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("t6_fail",   32'(fail), 32'd1);
        chk("t6_result", result,    32'd101);
        read_chk("t6_rd100", 32'd100, 32'd25);
`else
        chk("t6_fail",   32'(fail), 32'd0);
        chk("t6_done",   32'(done), 32'd0);
        read_chk("t6_rd100", 32'd100, 32'h0000_0077);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
